// File: rtl/cdac_pkg.sv
// Shared types and frame-format constants for the DAC readback receiver.
package cdac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } cdac_state_e;

  localparam int CDAC_FRAME_BITS = 16;
  localparam int CDAC_DATA_MSB   = 12;
  localparam int CDAC_DATA_LSB   = 1;
  localparam int CDAC_PAD_BITS   = 3;
  localparam int CDAC_DATA_W     = CDAC_DATA_MSB - CDAC_DATA_LSB + 1;

endpackage

// File: rtl/cdac_sync_edge.sv
// Three-flop synchronizer with rise/fall strobes for one asynchronous input.
// Stages 0/1 synchronize, stage 2 is the previous synchronized value used for
// edge detection. Optional triplication votes the chain every cycle.
module cdac_sync_edge #(
  parameter logic RST_VAL = 1'b0,
  parameter int   TMR     = 0
) (
  input  logic CLK40,
  input  logic RST,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int NC = (TMR != 0) ? 3 : 1;

  logic [2:0] ch_q [NC];
  logic [2:0] ch_v;

  generate
    if (TMR != 0) begin : g_vote
      assign ch_v = (ch_q[0] & ch_q[1]) | (ch_q[0] & ch_q[2]) | (ch_q[1] & ch_q[2]);
    end else begin : g_single
      assign ch_v = ch_q[0];
    end
  endgenerate

  // Shift the pin into the chain; every copy reloads from the voted value.
  always_ff @(posedge CLK40 or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NC; i++) ch_q[i] <= {3{RST_VAL}};
    end else begin
      for (int i = 0; i < NC; i++) ch_q[i] <= {ch_v[1:0], d_i};
    end
  end

  assign sync_o = ch_v[1];
  assign rise_o = ch_v[1] & ~ch_v[2];
  assign fall_o = ~ch_v[1] & ch_v[2];

endmodule

// File: rtl/cdac_rb_rx.sv
// Readback receiver for the threshold DAC serial link. Deserializes each
// DAC_ENB-framed 16-bit word, checks pad bits and count, and presents the
// recovered 12-bit threshold with sticky done/error flags and a frame count.
module cdac_rb_rx
  import cdac_pkg::*;
#(
  parameter int TMR = 0
) (
  input  logic                   CLK40,
  input  logic                   RST,
  input  logic                   SCLK,
  input  logic                   SDATA,
  input  logic                   DAC_ENB,
  input  logic                   CLR_RB,
  output logic [CDAC_DATA_W-1:0] RB_DATA,
  output logic                   RB_VALID,
  output logic                   RB_DONE,
  output logic                   FRAME_ERR,
  output logic [7:0]             FRAME_CNT
);

  localparam int NC = (TMR != 0) ? 3 : 1;

  // All protected state lives in one struct so triplication and voting
  // cover every register uniformly.
  typedef struct packed {
    cdac_state_e                state;
    logic [CDAC_FRAME_BITS-1:0] shreg;
    logic [4:0]                 cnt;
    logic [CDAC_DATA_W-1:0]     data;
    logic                       valid;
    logic                       done;
    logic                       err;
    logic [7:0]                 fcnt;
  } rx_st_t;

  rx_st_t st_q [NC];
  rx_st_t v;

  logic sclk_rise, sclk_fall, sclk_s;
  logic enb_rise, enb_fall, enb_s;
  logic sdata_s, sdata_rise, sdata_fall;
  logic frame_good;
  logic sig_unused;

  cdac_sync_edge #(.RST_VAL(1'b0), .TMR(TMR)) u_sync_sclk (
    .CLK40(CLK40), .RST(RST), .d_i(SCLK),
    .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // Enable chain resets high so an enable already asserted at reset release
  // does not look like a new frame start.
  cdac_sync_edge #(.RST_VAL(1'b1), .TMR(TMR)) u_sync_enb (
    .CLK40(CLK40), .RST(RST), .d_i(DAC_ENB),
    .sync_o(enb_s), .rise_o(enb_rise), .fall_o(enb_fall)
  );

  cdac_sync_edge #(.RST_VAL(1'b0), .TMR(TMR)) u_sync_sdata (
    .CLK40(CLK40), .RST(RST), .d_i(SDATA),
    .sync_o(sdata_s), .rise_o(sdata_rise), .fall_o(sdata_fall)
  );

  assign sig_unused = &{sclk_s, sclk_fall, enb_s, sdata_rise, sdata_fall};

  generate
    if (TMR != 0) begin : g_vote
      assign v = rx_st_t'((st_q[0] & st_q[1]) | (st_q[0] & st_q[2]) | (st_q[1] & st_q[2]));
    end else begin : g_single
      assign v = st_q[0];
    end
  endgenerate

  assign frame_good = (v.cnt == 5'(CDAC_FRAME_BITS))
                   && (v.shreg[CDAC_FRAME_BITS-1 -: CDAC_PAD_BITS] == '0)
                   && !v.shreg[0];

  // Receiver FSM; each copy is rewritten from the voted state every cycle.
  // Clear is written before the CHECK update so a coincident set wins.
  always_ff @(posedge CLK40 or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NC; i++) st_q[i] <= '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        st_q[i]       <= v;
        st_q[i].valid <= 1'b0;
        if (CLR_RB) begin
          st_q[i].done <= 1'b0;
          st_q[i].err  <= 1'b0;
        end
        case (v.state)
          IDLE: begin
            st_q[i].shreg <= '0;
            st_q[i].cnt   <= '0;
            if (enb_rise) st_q[i].state <= SHIFT;
          end
          SHIFT: begin
            // A shift coincident with the enable fall still lands before CHECK.
            if (sclk_rise) begin
              st_q[i].shreg <= {v.shreg[CDAC_FRAME_BITS-2:0], sdata_s};
              if (v.cnt != 5'd31) st_q[i].cnt <= v.cnt + 5'd1;
            end
            if (enb_fall) st_q[i].state <= CHECK;
          end
          CHECK: begin
            st_q[i].state <= IDLE;
            st_q[i].valid <= 1'b1;
            st_q[i].fcnt  <= v.fcnt + 8'd1;
            if (frame_good) begin
              st_q[i].data <= v.shreg[CDAC_DATA_MSB:CDAC_DATA_LSB];
              st_q[i].done <= 1'b1;
            end else begin
              st_q[i].err  <= 1'b1;
            end
          end
          default: st_q[i].state <= IDLE;
        endcase
      end
    end
  end

  assign RB_DATA   = v.data;
  assign RB_VALID  = v.valid;
  assign RB_DONE   = v.done;
  assign FRAME_ERR = v.err;
  assign FRAME_CNT = v.fcnt;

endmodule

// File: tb/tb_cdac_rb_rx.sv
// Directed bench for cdac_rb_rx: frame-level model checked every cycle plus
// hand-computed literal expectations.
`timescale 1ns/1ps
module tb_cdac_rb_rx;

  logic        CLK40 = 1'b0;
  logic        RST = 1'b0, SCLK = 1'b0, SDATA = 1'b0, DAC_ENB = 1'b0, CLR_RB = 1'b0;
  logic [11:0] RB_DATA;
  logic        RB_VALID, RB_DONE, FRAME_ERR;
  logic [7:0]  FRAME_CNT;

  cdac_rb_rx #(.TMR(1)) dut (
    .CLK40(CLK40), .RST(RST), .SCLK(SCLK), .SDATA(SDATA), .DAC_ENB(DAC_ENB),
    .CLR_RB(CLR_RB), .RB_DATA(RB_DATA), .RB_VALID(RB_VALID), .RB_DONE(RB_DONE),
    .FRAME_ERR(FRAME_ERR), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK40 = ~CLK40;

  int cyc = 0;
  always @(posedge CLK40) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  bit run = 0;

  // frame-level model state
  logic [11:0] m_data = '0;
  logic        m_done = 0, m_err = 0;
  logic [7:0]  m_cnt = '0;
  int          pend_cyc = -1, clr_cyc = -1, fall_cyc = 0, last_valid_cyc = -1;
  bit          pend_good = 0;
  logic [11:0] pend_data = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // compare process: outputs must equal the frame-level model every cycle
  initial begin
    logic exp_valid;
    wait (run);
    forever begin
      @(negedge CLK40);
      exp_valid = 1'b0;
      if (RST) begin
        m_data = '0; m_done = 0; m_err = 0; m_cnt = '0; pend_cyc = -1;
      end else begin
        if (cyc == clr_cyc) begin m_done = 0; m_err = 0; end
        if (cyc == pend_cyc) begin
          exp_valid = 1'b1;
          m_cnt = m_cnt + 8'd1;
          if (pend_good) begin m_data = pend_data; m_done = 1; end
          else m_err = 1;
          pend_cyc = -1;
        end
      end
      if (RB_VALID) last_valid_cyc = cyc;
      n_tests++;
      if (RB_DATA !== m_data || RB_VALID !== exp_valid || RB_DONE !== m_done ||
          FRAME_ERR !== m_err || FRAME_CNT !== m_cnt) begin
        n_fail++;
        $display("FAIL outputs cyc%0d got/exp data=%h/%h valid=%b/%b done=%b/%b err=%b/%b cnt=%0d/%0d",
                 cyc, RB_DATA, m_data, RB_VALID, exp_valid, RB_DONE, m_done,
                 FRAME_ERR, m_err, FRAME_CNT, m_cnt);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK40);
    #1;
  endtask

  task automatic clr();
    CLR_RB = 1; clr_cyc = cyc + 1;
    wait_cyc(1);
    CLR_RB = 0;
    wait_cyc(2);
  endtask

  // Send the top n bits of w MSB first inside a DAC_ENB frame.
  task automatic frame(input logic [15:0] w, input int n, input int half,
                       input bit coinc, input bit clr_chk);
    DAC_ENB = 1;
    wait_cyc(half);
    for (int b = 0; b < n; b++) begin
      SDATA = w[15-b];
      wait_cyc(half);
      if (coinc && b == n-1) begin
        SCLK = 1; DAC_ENB = 0;
      end else begin
        SCLK = 1; wait_cyc(half); SCLK = 0;
      end
    end
    if (!coinc) begin wait_cyc(half); DAC_ENB = 0; end
    fall_cyc  = cyc;
    pend_good = (n == 16) && (w[15:13] == 3'b000) && !w[0];
    pend_data = w[12:1];
    pend_cyc  = cyc + 4;
    if (clr_chk) begin
      wait_cyc(3);
      CLR_RB = 1; clr_cyc = cyc + 1;
      wait_cyc(1);
      CLR_RB = 0;
    end
    wait_cyc(8);
    SCLK = 0; SDATA = 0;
    wait_cyc(2);
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 RST = 1;
    @(posedge CLK40); #1;
    run = 1;
    wait_cyc(3);
    RST = 0;
    wait_cyc(3);
    chk("reset_data", RB_DATA, 0);
    chk("reset_cnt", FRAME_CNT, 0);
    chk("reset_flags", {RB_DONE, FRAME_ERR, RB_VALID}, 0);

    // good frame at 1 MHz SCLK
    frame(16'h0ABC, 16, 20, 0, 0);
    chk("f1_data", RB_DATA, 12'h55E);
    chk("f1_done", RB_DONE, 1);
    chk("f1_cnt", FRAME_CNT, 1);
    chk("f1_latency", last_valid_cyc - fall_cyc, 4);

    // short frame
    clr();
    frame(16'h1234, 15, 5, 0, 0);
    chk("short_err", FRAME_ERR, 1);
    chk("short_done", RB_DONE, 0);
    chk("short_data", RB_DATA, 12'h55E);
    chk("short_cnt", FRAME_CNT, 2);

    // pad bit set, clear, good all-ones data
    clr();
    frame(16'h8002, 16, 5, 0, 0);
    chk("pad_err", FRAME_ERR, 1);
    chk("pad_data", RB_DATA, 12'h55E);
    clr();
    chk("clr_flags", {RB_DONE, FRAME_ERR}, 0);
    frame(16'h1FFE, 16, 5, 0, 0);
    chk("ones_data", RB_DATA, 12'hFFF);
    chk("ones_done", RB_DONE, 1);
    chk("ones_cnt", FRAME_CNT, 4);

    // reset mid-frame
    DAC_ENB = 1;
    wait_cyc(5);
    for (int b = 0; b < 8; b++) begin
      SDATA = b[0]; wait_cyc(5); SCLK = 1; wait_cyc(5); SCLK = 0;
    end
    RST = 1;
    wait_cyc(2);
    RST = 0;
    wait_cyc(3);
    chk("rst_mid_out", {RB_DATA, FRAME_CNT, RB_DONE, FRAME_ERR}, 0);
    DAC_ENB = 0;
    wait_cyc(12);
    chk("rst_mid_novalid", FRAME_CNT, 0);
    frame(16'h0002, 16, 5, 0, 0);
    chk("after_rst_data", RB_DATA, 12'h001);
    chk("after_rst_cnt", FRAME_CNT, 1);

    // wrap the frame counter; one frame has CLR_RB coincident with CHECK
    for (int i = 0; i < 255; i++) begin
      logic [11:0] dv;
      dv = 12'(i * 37 + 5);
      if (i == 100) begin
        clr();
        frame({3'b000, dv, 1'b0}, 16, 5, 0, 1);
        chk("clr_vs_set_done", RB_DONE, 1);
      end else begin
        frame({3'b000, dv, 1'b0}, 16, 5, 0, 0);
      end
    end
    chk("wrap_cnt", FRAME_CNT, 0);
    chk("wrap_data", RB_DATA, 12'(254 * 37 + 5));

    // final SCLK rise coincident with enable fall
    clr();
    frame(16'h0246, 16, 5, 1, 0);
    chk("coinc_data", RB_DATA, 12'h123);
    chk("coinc_done", RB_DONE, 1);
    chk("coinc_err", FRAME_ERR, 0);
    chk("coinc_cnt", FRAME_CNT, 1);

    wait_cyc(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
